if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the address of the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, interrupt entry and exception entry. The ID stage consumes its outputs.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage_if_id_reg.sv | 26 ++
 rtl/if_stage.sv | 55 +++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared CPU constants, IF/ID record and PC increment helper
package if_stage_pkg;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] IRQ_PC     = 32'h8000_0004;
  localparam logic [31:0] EXC_PC     = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          KERNEL_BIT = 31;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Sequential PC: the kernel bit is sticky, the low 31 bits wrap
  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return {pc[KERNEL_BIT], pc[30:0] + 31'd4};
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: ROM, hazard/redirect/interrupt controls and IF/ID outputs of the fetch stage
interface if_stage_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        exc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        irq_taken;
  logic [31:0] epc;

  // master: ROM plus downstream control; slave: the fetch stage
  modport master (
    output rom_data, stall, flush, redirect_valid, redirect_pc, irq, exc,
    input  rom_addr, id_instr, id_pc, id_pc_plus4, id_valid, irq_taken, epc
  );
  modport slave (
    input  rom_data, stall, flush, redirect_valid, redirect_pc, irq, exc,
    output rom_addr, id_instr, id_pc, id_pc_plus4, id_valid, irq_taken, epc
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and bubble-load controls
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output if_id_t      q_o
);
  if_id_t q_q, q_d;

  // Hold keeps the entry; a bubble keeps the PC fields but squashes the word
  always_comb q_d = hold_i ? q_q : if_id_t'{instr: bubble_i ? NOP_INSTR : instr_i,
                                            pc: pc_i, pc_plus4: pc_plus4_i, valid: !bubble_i};

  // Register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) q_q <= '0;
    else q_q <= q_d;

  assign q_o = q_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, next-PC priority mux, interrupt entry and IF/ID capture
module if_stage
  import if_stage_pkg::*;
(
  input logic       clk,
  input logic       reset,
  if_stage_if.slave bus
);
  logic [31:0] pc_q, pc_d, epc_q, epc_d, seq;
  logic        irq_taken_q, irq_acc, hold, bubble;
  if_id_t      id;

  assign seq = pc_seq(pc_q);
  assign irq_acc = bus.irq & ~pc_q[KERNEL_BIT] & ~bus.exc & ~bus.stall;

  // Next PC by priority exc > irq > redirect > stall > sequential; epc captures the return point
  always_comb begin
    pc_d = bus.exc ? EXC_PC : irq_acc ? IRQ_PC : bus.redirect_valid ? bus.redirect_pc :
           bus.stall ? pc_q : seq;
    epc_d = irq_acc ? (bus.redirect_valid ? bus.redirect_pc : pc_q) : epc_q;
    bubble = bus.exc | irq_acc | bus.redirect_valid | bus.flush;
    hold = bus.stall & ~bus.exc & ~bus.redirect_valid;
  end

  // PC and interrupt-entry state with asynchronous reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_q <= RESET_PC;
      epc_q <= '0;
      irq_taken_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      epc_q <= epc_d;
      irq_taken_q <= irq_acc;
    end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n_i   (reset),
    .hold_i    (hold),
    .bubble_i  (bubble),
    .instr_i   (bus.rom_data),
    .pc_i      (pc_q),
    .pc_plus4_i(seq),
    .q_o       (id)
  );

  assign bus.rom_addr = pc_q;
  assign bus.id_instr = id.instr;
  assign bus.id_pc = id.pc;
  assign bus.id_pc_plus4 = id.pc_plus4;
  assign bus.id_valid = id.valid;
  assign bus.irq_taken = irq_taken_q;
  assign bus.epc = epc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed table, corner sequences and random stimulus against a reference model
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus();
  if_stage dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] rom [128];
  assign bus.rom_data = rom[bus.rom_addr[8:2]];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_epc;
  logic        m_valid, m_taken;

  typedef struct {
    logic        stall, flush, rv;
    logic [31:0] rpc;
    logic        irq, exc;
    logic [31:0] exp_pc;
    logic        exp_valid, exp_taken;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_instr = '0;
    m_ipc = '0;
    m_ipc4 = '0;
    m_epc = '0;
    m_valid = 1'b0;
    m_taken = 1'b0;
  endtask

  task automatic model_bubble(input logic [31:0] nxt);
    m_instr = 32'h0;
    m_valid = 1'b0;
    m_ipc = m_pc;
    m_ipc4 = nxt;
  endtask

  // Reference behaviour for one rising edge, written straight from the priority list
  task automatic model_step();
    logic [31:0] nxt;
    logic        acc;
    nxt = {m_pc[31], 31'((m_pc[30:0] + 32'd4) % 32'h8000_0000)};
    acc = bus.irq && !m_pc[31] && !bus.exc && !bus.stall;
    m_taken = acc;
    if (bus.exc) begin
      model_bubble(nxt);
      m_pc = 32'h8000_0008;
    end else if (acc) begin
      m_epc = bus.redirect_valid ? bus.redirect_pc : m_pc;
      model_bubble(nxt);
      m_pc = 32'h8000_0004;
    end else if (bus.redirect_valid) begin
      model_bubble(nxt);
      m_pc = bus.redirect_pc;
    end else if (!bus.stall) begin
      if (bus.flush) model_bubble(nxt);
      else begin
        m_instr = rom[m_pc[8:2]];
        m_valid = 1'b1;
        m_ipc = m_pc;
        m_ipc4 = nxt;
      end
      m_pc = nxt;
    end
  endtask

  task automatic check_all();
    chk("rom_addr", bus.rom_addr, m_pc);
    chk("id_instr", bus.id_instr, m_instr);
    chk("id_pc", bus.id_pc, m_ipc);
    chk("id_pc_plus4", bus.id_pc_plus4, m_ipc4);
    chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
    chk("irq_taken", 32'(bus.irq_taken), 32'(m_taken));
    chk("epc", bus.epc, m_epc);
  endtask

  task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                       input logic iq, input logic ex);
    bus.stall = st;
    bus.flush = fl;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.irq = iq;
    bus.exc = ex;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic vec_t v(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                             input logic iq, input logic ex, input logic [31:0] epc_,
                             input logic ev, input logic et);
    vec_t r;
    r.stall = st; r.flush = fl; r.rv = rv; r.rpc = rpc; r.irq = iq; r.exc = ex;
    r.exp_pc = epc_; r.exp_valid = ev; r.exp_taken = et;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    tbl[0]  = v(0, 0, 0, 32'h0,         0, 0, 32'h8000_0004, 1, 0);
    tbl[1]  = v(0, 0, 0, 32'h0,         0, 0, 32'h8000_0008, 1, 0);
    tbl[2]  = v(0, 0, 1, 32'h0000_000C, 0, 0, 32'h0000_000C, 0, 0);
    tbl[3]  = v(0, 0, 0, 32'h0,         0, 0, 32'h0000_0010, 1, 0);
    tbl[4]  = v(1, 1, 0, 32'h0,         0, 0, 32'h0000_0010, 1, 0);
    tbl[5]  = v(1, 0, 0, 32'h0,         1, 0, 32'h0000_0010, 1, 0);
    tbl[6]  = v(1, 0, 0, 32'h0,         0, 0, 32'h0000_0010, 1, 0);
    tbl[7]  = v(0, 0, 0, 32'h0,         0, 0, 32'h0000_0014, 1, 0);
    tbl[8]  = v(0, 0, 1, 32'h0000_0040, 0, 0, 32'h0000_0040, 0, 0);
    tbl[9]  = v(0, 0, 1, 32'h0000_0078, 0, 0, 32'h0000_0078, 0, 0);
    tbl[10] = v(0, 0, 0, 32'h0,         0, 0, 32'h0000_007C, 1, 0);
    tbl[11] = v(0, 0, 1, 32'h0000_0100, 0, 0, 32'h0000_0100, 0, 0);
    tbl[12] = v(0, 0, 0, 32'h0,         1, 0, 32'h8000_0004, 0, 1);
    tbl[13] = v(0, 0, 0, 32'h0,         1, 0, 32'h8000_0008, 1, 0);
    tbl[14] = v(0, 0, 0, 32'h0,         1, 0, 32'h8000_000C, 1, 0);
    tbl[15] = v(0, 0, 1, 32'h0000_01F0, 0, 0, 32'h0000_01F0, 0, 0);
    tbl[16] = v(0, 0, 1, 32'h0000_0200, 1, 0, 32'h8000_0004, 0, 1);
    tbl[17] = v(0, 0, 1, 32'h0000_0300, 0, 0, 32'h0000_0300, 0, 0);
    tbl[18] = v(1, 0, 0, 32'h0,         1, 1, 32'h8000_0008, 0, 0);
    tbl[19] = v(0, 0, 0, 32'h0,         0, 0, 32'h8000_000C, 1, 0);
    tbl[20] = v(0, 1, 0, 32'h0,         0, 0, 32'h8000_0010, 0, 0);
    tbl[21] = v(0, 0, 1, 32'h7FFF_FFFC, 0, 0, 32'h7FFF_FFFC, 0, 0);
    tbl[22] = v(0, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 1, 0);
    tbl[23] = v(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0);
    tbl[24] = v(0, 0, 0, 32'h0,         0, 0, 32'h8000_0000, 1, 0);
    tbl[25] = v(0, 0, 1, 32'h0000_011C, 0, 0, 32'h0000_011C, 0, 0);
    tbl[26] = v(0, 0, 0, 32'h0,         0, 0, 32'h0000_0120, 1, 0);
    tbl[27] = v(0, 0, 0, 32'h0,         0, 0, 32'h0000_0124, 1, 0);

    drive(0, 0, 0, 32'h0, 0, 0);
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].rv, tbl[i].rpc, tbl[i].irq, tbl[i].exc);
      cyc();
      chk($sformatf("tbl%0d_pc", i), bus.rom_addr, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.id_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_taken", i), 32'(bus.irq_taken), 32'(tbl[i].exp_taken));
    end
    chk("epc_after_irq_redirect", bus.epc, 32'h0000_0200);

    drive(0, 0, 0, 32'h0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_reset_pc", bus.rom_addr, RESET_PC);
    chk("async_reset_valid", 32'(bus.id_valid), 32'h0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("first_fetch_instr", bus.id_instr, rom[0]);
    chk("first_fetch_pc", bus.id_pc, RESET_PC);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(5) == 0,
            {$urandom_range(3) == 0 ? 1'b1 : 1'b0, 22'h0, 7'($urandom), 2'b00},
            $urandom_range(2) == 0, $urandom_range(11) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
